// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bus bundle between the issue/writeback stages and regfile_sb.
//
// Signals
//   AD1/AD2, RE      read addresses and read enable
//   RD1/RD2          registered read data
//   AD3/WE3/WD3      write port
//   ISSUE/ISSUE_RD   destination of the instruction issued this cycle
//   USE1/USE2        AD1/AD2 carry real source operands
//   STALL            combinational hazard flag
//   BUSY             scoreboard vector, one bit per register
//   a0               registered copy of the mirrored register
// Modports: master = pipeline side, slave = register file.
interface regfile_sb_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] AD1;
    logic [ADDRESS_WIDTH-1:0] AD2;
    logic                     RE;
    logic [DATA_WIDTH-1:0]    RD1;
    logic [DATA_WIDTH-1:0]    RD2;
    logic [ADDRESS_WIDTH-1:0] AD3;
    logic                     WE3;
    logic [DATA_WIDTH-1:0]    WD3;
    logic                     ISSUE;
    logic [ADDRESS_WIDTH-1:0] ISSUE_RD;
    logic                     USE1;
    logic                     USE2;
    logic                     STALL;
    logic [DEPTH-1:0]         BUSY;
    logic [DATA_WIDTH-1:0]    a0;

    modport master (
        output AD1, AD2, RE, AD3, WE3, WD3, ISSUE, ISSUE_RD, USE1, USE2,
        input  RD1, RD2, STALL, BUSY, a0
    );

    modport slave (
        input  AD1, AD2, RE, AD3, WE3, WD3, ISSUE, ISSUE_RD, USE1, USE2,
        output RD1, RD2, STALL, BUSY, a0
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- two-read/one-write register file with write-to-read bypass,
// pending-write scoreboard (drives the decode stall) and a registered debug
// tap of one register.
//
// Ports
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset, clears every register and flag
//   bus    regfile_sb_if.slave: read ports, write port, issue/scoreboard
//          signals, STALL, BUSY and the a0 tap
module regfile_sb #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1,
    parameter int A0_INDEX      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] A0_ADDR = ADDRESS_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]      busy_reg;
    logic [DEPTH-1:0]      busy_next;
    logic [DATA_WIDTH-1:0] rd1_reg;
    logic [DATA_WIDTH-1:0] rd2_reg;
    logic [DATA_WIDTH-1:0] a0_reg;
    logic [DATA_WIDTH-1:0] rd1_next;
    logic [DATA_WIDTH-1:0] rd2_next;
    logic [DATA_WIDTH-1:0] a0_next;
    logic                  wr_en;

    // Architectural value of a register as seen by a reader this cycle:
    // hardwired zero first, then the in-flight write (when bypassing), then storage.
    function automatic logic [DATA_WIDTH-1:0] read_value(
        input logic [ADDRESS_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0]    stored,
        input logic                     we,
        input logic [ADDRESS_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0]    wd
    );
        if (ZERO_REG != 0 && addr == '0)
            return '0;
        else if (BYPASS != 0 && we && wa == addr)
            return wd;
        else
            return stored;
    endfunction

    // A busy register stops being a hazard in the very cycle its result
    // is being written back, provided that result is forwarded.
    function automatic logic busy_eff(
        input logic [ADDRESS_WIDTH-1:0] addr,
        input logic                     busy_bit,
        input logic                     we,
        input logic [ADDRESS_WIDTH-1:0] wa
    );
        if (ZERO_REG != 0 && addr == '0)
            return 1'b0;
        else if (BYPASS != 0 && we && wa == addr)
            return 1'b0;
        else
            return busy_bit;
    endfunction

    // Writes to register 0 are dropped when it is hardwired.
    assign wr_en = bus.WE3 && !(ZERO_REG != 0 && bus.AD3 == '0);

    assign rd1_next = read_value(bus.AD1, regs_reg[bus.AD1], bus.WE3, bus.AD3, bus.WD3);
    assign rd2_next = read_value(bus.AD2, regs_reg[bus.AD2], bus.WE3, bus.AD3, bus.WD3);
    assign a0_next  = read_value(A0_ADDR, regs_reg[A0_ADDR], bus.WE3, bus.AD3, bus.WD3);

    // Scoreboard next state per register: a new producer (set) supersedes
    // the retiring one (clear) when both hit the same register on one edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit = bus.ISSUE && bus.ISSUE_RD == ADDRESS_WIDTH'(gi)
                             && !(ZERO_REG != 0 && gi == 0);
            assign clr_hit = bus.WE3 && bus.AD3 == ADDRESS_WIDTH'(gi);
            assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs_reg[i] <= '0;
        end else if (wr_en) begin
            regs_reg[bus.AD3] <= bus.WD3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
            rd1_reg  <= '0;
            rd2_reg  <= '0;
            a0_reg   <= '0;
        end else begin
            busy_reg <= busy_next;
            a0_reg   <= a0_next;
            if (bus.RE) begin
                rd1_reg <= rd1_next;
                rd2_reg <= rd2_next;
            end
        end
    end

    assign bus.STALL = (bus.USE1 && busy_eff(bus.AD1, busy_reg[bus.AD1], bus.WE3, bus.AD3))
                     | (bus.USE2 && busy_eff(bus.AD2, busy_reg[bus.AD2], bus.WE3, bus.AD3));
    assign bus.BUSY  = busy_reg;
    assign bus.RD1   = rd1_reg;
    assign bus.RD2   = rd2_reg;
    assign bus.a0    = a0_reg;
endmodule
